// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32i constants and types
//
// Purpose: constants and types shared by the fetch stage and the control path.
//   RV32I_NOP      - canonical NOP (addi x0, x0, 0), also used by the stall mux.
//   RV32I_RESET_PC - default PC of the first fetch after reset.
//   fetch_entry_t  - one instruction-queue entry {pc, instr}.
package rv32i_pkg;

  localparam logic [31:0] RV32I_NOP      = 32'h0000_0013;
  localparam logic [31:0] RV32I_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// rtl/rv32i_fetch_fifo.sv - small synchronous FIFO with flush
//
// Purpose: in-order queue used both for fetched instructions and for the PCs
// of outstanding imem requests.
// Ports:
//   clk_i, resetn_i - clock (rising edge), asynchronous active-low reset
//   flush_i         - empties the FIFO; wins over push/pop in the same cycle
//   push_i, push_data_i - write one entry
//   pop_i           - drop the head entry (ignored when empty)
//   head_o          - data at the head (meaningless when empty_o=1)
//   full_o, empty_o, count_o - occupancy status
module rv32i_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rv32i_fetch_stage.sv
// rtl/rv32i_fetch_stage.sv - RV32i instruction-fetch stage
//
// Purpose: owns the fetch PC, issues pipelined imem requests, buffers the
// returned words in order and presents one instruction per cycle to decode.
// Ports:
//   clk_i, resetn_i          - clock, asynchronous active-low reset
//   stall_i                  - decode holds the current instruction
//   redirect_i, redirect_pc_i - execute-stage redirect and its target
//   imem_req_o, imem_addr_o  - request valid / word-aligned address
//   imem_gnt_i               - request accepted this cycle
//   imem_rvalid_i, imem_rdata_i - in-order response
//   instruction_o, pc_o, pc_plus4_o, valid_o - instruction to decode
module rv32i_fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RV32I_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 2;

  logic [31:0]  fetch_pc_q;
  logic [CW-1:0] discard_q;

  // Instruction queue.
  fetch_entry_t iq_wdata;
  fetch_entry_t iq_head;
  logic         iq_full;
  logic         iq_empty;
  logic [CW-1:0] iq_count;

  // PC queue: one entry per outstanding request, so its count is the
  // outstanding counter.
  logic [31:0]  pcq_head;
  logic         pcq_full;
  logic         pcq_empty;
  logic [CW-1:0] outstanding;

  logic [SW-1:0] in_flight;
  logic          grant;
  logic          resp_keep;
  logic          resp_drop;
  logic          consume;
  logic          unused_sigs;

  // Every slot is reserved from grant until the word leaves the queue, and
  // discarded responses still occupy a slot until they arrive.
  assign in_flight  = SW'(iq_count) + SW'(outstanding) + SW'(discard_q);
  assign imem_req_o = resetn_i & (in_flight < SW'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc_q;

  assign grant     = imem_req_o & imem_gnt_i;
  assign resp_drop = imem_rvalid_i & (discard_q != '0);
  assign resp_keep = imem_rvalid_i & (discard_q == '0);
  assign consume   = valid_o & ~stall_i & ~redirect_i;

  assign iq_wdata.pc    = pcq_head;
  assign iq_wdata.instr = imem_rdata_i;

  rv32i_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_instr_q (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .flush_i     (redirect_i),
    .push_i      (resp_keep),
    .push_data_i (iq_wdata),
    .pop_i       (consume),
    .head_o      (iq_head),
    .full_o      (iq_full),
    .empty_o     (iq_empty),
    .count_o     (iq_count)
  );

  rv32i_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_pc_q (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .flush_i     (redirect_i),
    .push_i      (grant),
    .push_data_i (fetch_pc_q),
    .pop_i       (resp_keep),
    .head_o      (pcq_head),
    .full_o      (pcq_full),
    .empty_o     (pcq_empty),
    .count_o     (outstanding)
  );

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else if (redirect_i) begin
      fetch_pc_q <= {redirect_pc_i[31:2], 2'b00};
      // Everything still in flight, including a request granted right now,
      // becomes a response to drop; a response arriving now is already gone.
      discard_q  <= discard_q + outstanding + CW'(grant) - CW'(imem_rvalid_i);
    end else begin
      if (grant) fetch_pc_q <= fetch_pc_q + 32'd4;
      discard_q <= discard_q - CW'(resp_drop);
    end
  end

  assign valid_o       = ~iq_empty;
  assign instruction_o = valid_o ? iq_head.instr : RV32I_NOP;
  // With nothing to show, pc_o tracks the next fetch address (RESET_PC after reset).
  assign pc_o          = valid_o ? iq_head.pc : fetch_pc_q;
  assign pc_plus4_o    = pc_o + 32'd4;

  // Status outputs the request rule already makes redundant, and the
  // alignment bits of the redirect target.
  assign unused_sigs = &{1'b0, iq_full, pcq_full, pcq_empty, redirect_pc_i[1:0]};

endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// tb/tb_rv32i_fetch_stage.sv - self-checking bench for rv32i_fetch_stage
module tb_rv32i_fetch_stage;

  localparam int          D   = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;

  always #5 clk = ~clk;

  rv32i_fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
    .clk_i         (clk),
    .resetn_i      (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instruction_o (instruction_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .valid_o       (valid_o)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: queue of delivered instructions, PCs of live requests,
  // number of responses still to drop, next fetch PC.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic [31:0] mout[$];
  int          mdisc;
  logic [31:0] mpc;

  // Imem responder: granted requests waiting for their response.
  typedef struct { logic [31:0] data; int ready; } pend_t;
  pend_t pend[$];

  task automatic model_reset();
    mq.delete();
    mout.delete();
    pend.delete();
    mdisc = 0;
    mpc = RPC;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_req();
    return rst_n && ((mq.size() + mout.size() + mdisc) < D);
  endfunction

  task automatic check_outputs();
    bit er;
    er = model_req();
    chk("imem_req", 32'(imem_req_o), 32'(er));
    if (er) chk("imem_addr", imem_addr_o, mpc);
    chk("valid", 32'(valid_o), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("instr", instruction_o, mq[0].instr);
      chk("pc", pc_o, mq[0].pc);
      chk("pc_plus4", pc_plus4_o, mq[0].pc + 32'd4);
    end else begin
      chk("instr_nop", instruction_o, 32'h0000_0013);
    end
    if (!rst_n) begin
      chk("reset_pc", pc_o, RPC);
      chk("reset_pc4", pc_plus4_o, RPC + 32'd4);
    end
  endtask

  // One clock cycle: drive reset at the falling edge, check, drive inputs,
  // then advance the model across the rising edge.
  task automatic step(bit rst, bit g, bit rv_en, bit st, bit rd, logic [31:0] tgt);
    bit          rv, er, gr, pop;
    logic [31:0] rdata, p;
    @(negedge clk);
    rst_n = rst;
    #1;
    if (!rst) model_reset();
    check_outputs();
    rv = rst && rv_en && (pend.size() > 0) && (pend[0].ready <= cyc);
    rdata = rv ? pend[0].data : $urandom;
    imem_gnt_i    = g;
    imem_rvalid_i = rv;
    imem_rdata_i  = rdata;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    er  = model_req();
    gr  = er && g;
    pop = (mq.size() > 0) && !st && !rd;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (pop) void'(mq.pop_front());
      if (rv) begin
        void'(pend.pop_front());
        if (mdisc > 0) mdisc--;
        else begin
          p = mout.pop_front();
          mq.push_back('{p, rdata});
        end
      end
      if (gr) begin
        pend.push_back('{$urandom, cyc + 1});
        mout.push_back(mpc);
        mpc = mpc + 32'd4;
      end
      if (rd) begin
        mq.delete();
        mdisc += mout.size();
        mout.delete();
        mpc = tgt & ~32'd3;
      end
    end
    cyc++;
  endtask

  initial begin
    model_reset();
    // Reset held.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Zero-wait streaming from RESET_PC.
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0, 0);
    // Stall three cycles: queue fills, head holds, requests stop.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0, 0);
    // Grant withheld four cycles: request and address hold.
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 0, 0);
    // Two requests outstanding, then redirect to a misaligned target.
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h0000_0103);
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0, 0);
    // Redirect in the same cycle as a response and a grant.
    for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 32'h0000_0200);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0, 0);
    // Reset pulsed mid-stream, then restart from RESET_PC.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0),
           $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
